fft_r2_iter_core: RTL
=====================

// Module: fft_r2_iter_core
// PURPOSE
//  Parametrised iterative radix-2 DIT FFT engine with streamed load/unload and an in-place register file.
//  One butterfly per clk; twiddles come from an external combinational ROM/mux via tw_idx.
//  Sits between the sample capture front end and the spectrum consumer.
//  Supersedes the fixed 64-point in-place butterfly array: adds handshakes, signed rounding and overflow control.
// PARAMETERS
//  N_PTS    64  transform length; power of 2, 4..1024
//  LOG2N    6   log2(N_PTS); must match N_PTS
//  DATA_W   16  signed sample width (re and im each)
//  TW_W     10  signed twiddle width, Q1.(TW_W-2); +1.0 = 2^(TW_W-2)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          input sample valid
//  in_ready   out  1          engine accepts input (LOAD state)
//  in_re      in   DATA_W     input sample real, signed
//  in_im      in   DATA_W     input sample imag, signed
//  out_valid  out  1          output bin valid (UNLOAD state)
//  out_ready  in   1          consumer accepts bin
//  out_re     out  DATA_W     output bin real, signed
//  out_im     out  DATA_W     output bin imag, signed
//  busy       out  1          high in COMPUTE
//  done       out  1          1-cycle pulse on COMPUTE->UNLOAD
//  tw_idx     out  LOG2N-1    twiddle index k into W_N^k, k<N/2
//  tw_re      in   TW_W       cos(2*pi*k/N), same cycle as tw_idx
//  tw_im      in   TW_W       -sin(2*pi*k/N), same cycle as tw_idx
// BEHAVIOUR
//  Reset: state=LOAD, counters=0; in_ready=1, out_valid=0, busy=0, done=0, tw_idx=0, out_re/out_im=0. Memory not cleared.
//  rst has priority in any state, including mid-COMPUTE/UNLOAD; the partial frame is dropped.
//  FSM LOAD -> COMPUTE -> UNLOAD -> LOAD.
//  LOAD: a beat is accepted on in_valid&in_ready. Sample n is written to mem[bitrev(n)].
//    After beat N_PTS-1 is accepted, the next cycle is COMPUTE and in_ready=0.
//  COMPUTE: stage s=0..LOG2N-1; butterfly b=0..N/2-1 within each stage.
//    half=2^s, k=b&(half-1), j=((b>>s)<<(s+1))|k, tw_idx=k<<(LOG2N-1-s).
//    t = round(mem[j+half]*W): complex product, add 2^(TW_W-3), arithmetic >>>(TW_W-2).
//    mem[j] <= mem[j]+t; mem[j+half] <= mem[j]-t. Sums are DATA_W+1 bits before the overflow rule.
//    Takes exactly LOG2N*N/2 cycles (192 at default). done pulses and UNLOAD begins on the cycle after the last butterfly.
//  UNLOAD: out_re/out_im = mem[m], natural order m=0..N-1, registered.
//    Data is held stable while out_valid&~out_ready. m advances on handshake.
//    After bin N-1 handshakes, the next cycle is LOAD with in_ready=1.
//  No overlap: in_ready=0 outside LOAD; in_valid is ignored there.
//  Wrap-around: all counters return to 0 on frame completion; no stale index carries into the next frame.
// CONFIGURATION
//  FFT_STAGE_SCALE_EN defined: each butterfly output is arithmetic >>>1 (truncate) before storage.
//    Full transform = X/N; overflow is impossible for in-range input.
//  Undefined: butterfly outputs saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; no scaling.
// TESTING
//  1 Impulse: x[0]=1000, rest 0, no scale -> every bin re=1000, im=0.
//    With FFT_STAGE_SCALE_EN -> every bin re=15, im=0.
//  2 DC: all x=100+0j, no scale -> bin0 re=6400; bins 1..63 = 0 (+/-1 LSB).
//  3 Shifted impulse: x[1]=1000 -> bin0=(1000,0), bin16=(0,-1000), bin32=(-1000,0), bin48=(0,1000), +/-2 LSB.
//  4 Saturation: all x=32767+0j, no scale -> bin0 re=32767 (clipped), im=0; no wrap to negative.
//  5 Backpressure: random out_ready and random in_valid gaps -> identical bins to test 3.
//    Outputs stable while stalled; busy high for exactly 192 cycles; done single pulse.
//  6 Reset mid-COMPUTE at butterfly 50 -> next cycle in_ready=1, busy=0, out_valid=0.
//    A following impulse frame gives test 1 results.

Source files
------------

// File: rtl/fft_r2_iter_core.sv
// fft_r2_iter_core: iterative radix-2 decimation-in-time FFT engine.
// Samples stream in (written bit-reversed), LOG2N stages of N/2 butterflies run
// one per clock against an external twiddle ROM addressed by tw_idx, and the
// bins stream out in natural order.
// Optional feature macro: FFT_STAGE_SCALE_EN -- halve every butterfly output
// (arithmetic shift, truncating) so the full transform yields X/N; without it
// butterfly outputs saturate to the DATA_W signed range.
module fft_r2_iter_core #(
    parameter int N_PTS  = 64,
    parameter int LOG2N  = 6,
    parameter int DATA_W = 16,
    parameter int TW_W   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_re,
    input  logic signed [DATA_W-1:0] in_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     busy,
    output logic                     done,
    output logic [LOG2N-2:0]         tw_idx,
    input  logic signed [TW_W-1:0]   tw_re,
    input  logic signed [TW_W-1:0]   tw_im
);

    localparam int STG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;
    localparam int ACC_W = DATA_W + TW_W + 1;
    localparam int SUM_W = DATA_W + 4;
    localparam int FRAC  = TW_W - 2;
    localparam logic [LOG2N-1:0]        LAST_IDX  = LOG2N'(N_PTS - 1);
    localparam logic [LOG2N-2:0]        LAST_BFLY = (LOG2N-1)'(N_PTS / 2 - 1);
    localparam logic [STG_W-1:0]        LAST_STG  = STG_W'(LOG2N - 1);
    localparam logic signed [ACC_W-1:0] RND       = ACC_W'(2 ** (TW_W - 3));

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [LOG2N-1:0]          idx_q, idx_d;      // sample index in LOAD, bin index in UNLOAD
    logic [STG_W-1:0]          stage_q, stage_d;
    logic [LOG2N-2:0]          bfly_q, bfly_d;
    logic signed [DATA_W-1:0]  out_re_q, out_re_d, out_im_q, out_im_d;
    logic                      done_q, done_d;
    logic                      ld_we_s, bf_we_s;

    logic signed [DATA_W-1:0]  mem_re_q [0:N_PTS-1];
    logic signed [DATA_W-1:0]  mem_im_q [0:N_PTS-1];

    logic [LOG2N-1:0]          b_ext_s, half_s, j_s, jh_s;
    logic [LOG2N-2:0]          mask_s, k_s, tw_idx_s;
    logic [STG_W:0]            shl_s;
    logic [STG_W-1:0]          shamt_s;
    logic signed [DATA_W-1:0]  p_re_s, p_im_s, a_re_s, a_im_s;
    logic signed [ACC_W-1:0]   ar_x, ai_x, wr_x, wi_x, acc_re_s, acc_im_s, rnd_re_s, rnd_im_s;
    logic signed [SUM_W-1:0]   t_re_s, t_im_s, sum_re_s, sum_im_s, dif_re_s, dif_im_s;
    logic signed [DATA_W-1:0]  u_re_s, u_im_s, l_re_s, l_im_s;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] hi, lo;
        hi = SUM_W'(2 ** (DATA_W - 1) - 1);
        lo = -hi - SUM_W'(1);
        if (v > hi) begin
            return hi[DATA_W-1:0];
        end else if (v < lo) begin
            return lo[DATA_W-1:0];
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    // Butterfly datapath: operand addresses, twiddle index, rounded product, sum/difference.
    always_comb begin
        b_ext_s  = {1'b0, bfly_q};
        half_s   = LOG2N'(1) << stage_q;
        mask_s   = (LOG2N-1)'(half_s - LOG2N'(1));
        k_s      = bfly_q & mask_s;
        shl_s    = (STG_W+1)'(stage_q) + (STG_W+1)'(1);
        j_s      = ((b_ext_s >> stage_q) << shl_s) | {1'b0, k_s};
        jh_s     = j_s + half_s;
        shamt_s  = LAST_STG - stage_q;
        tw_idx_s = k_s << shamt_s;
        p_re_s   = mem_re_q[j_s];
        p_im_s   = mem_im_q[j_s];
        a_re_s   = mem_re_q[jh_s];
        a_im_s   = mem_im_q[jh_s];
        ar_x     = ACC_W'(a_re_s);
        ai_x     = ACC_W'(a_im_s);
        wr_x     = ACC_W'(tw_re);
        wi_x     = ACC_W'(tw_im);
        acc_re_s = ar_x * wr_x - ai_x * wi_x;
        acc_im_s = ar_x * wi_x + ai_x * wr_x;
        rnd_re_s = (acc_re_s + RND) >>> FRAC;
        rnd_im_s = (acc_im_s + RND) >>> FRAC;
        t_re_s   = SUM_W'(rnd_re_s);
        t_im_s   = SUM_W'(rnd_im_s);
`ifdef FFT_STAGE_SCALE_EN
        sum_re_s = (SUM_W'(p_re_s) + t_re_s) >>> 1;
        sum_im_s = (SUM_W'(p_im_s) + t_im_s) >>> 1;
        dif_re_s = (SUM_W'(p_re_s) - t_re_s) >>> 1;
        dif_im_s = (SUM_W'(p_im_s) - t_im_s) >>> 1;
`else
        sum_re_s = SUM_W'(p_re_s) + t_re_s;
        sum_im_s = SUM_W'(p_im_s) + t_im_s;
        dif_re_s = SUM_W'(p_re_s) - t_re_s;
        dif_im_s = SUM_W'(p_im_s) - t_im_s;
`endif
        u_re_s   = sat(sum_re_s);
        u_im_s   = sat(sum_im_s);
        l_re_s   = sat(dif_re_s);
        l_im_s   = sat(dif_im_s);
    end

    // Frame sequencing: load counter, stage/butterfly counters, unload pointer and output register.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        stage_d  = stage_q;
        bfly_d   = bfly_q;
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        done_d   = 1'b0;
        ld_we_s  = 1'b0;
        bf_we_s  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    ld_we_s = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_COMPUTE;
                    end else begin
                        idx_d = idx_q + LOG2N'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_COMPUTE: begin
                bf_we_s = 1'b1;
                if (bfly_q == LAST_BFLY) begin
                    bfly_d = '0;
                    if (stage_q == LAST_STG) begin
                        // Last butterfly never touches slot 0, so bin 0 is already final here.
                        stage_d  = '0;
                        state_d  = ST_UNLOAD;
                        done_d   = 1'b1;
                        out_re_d = mem_re_q[0];
                        out_im_d = mem_im_q[0];
                    end else begin
                        stage_d = stage_q + STG_W'(1);
                    end
                end else begin
                    bfly_d = bfly_q + (LOG2N-1)'(1);
                end
            end
            ST_UNLOAD: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d    = idx_q + LOG2N'(1);
                        out_re_d = mem_re_q[idx_q + LOG2N'(1)];
                        out_im_d = mem_im_q[idx_q + LOG2N'(1)];
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = '0;
                stage_d = '0;
                bfly_d  = '0;
            end
        endcase
    end

    // Control and output registers; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            idx_q    <= '0;
            stage_q  <= '0;
            bfly_q   <= '0;
            out_re_q <= '0;
            out_im_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            stage_q  <= stage_d;
            bfly_q   <= bfly_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
            done_q   <= done_d;
        end
    end

    // In-place register file: a load beat fills its bit-reversed slot, a butterfly rewrites its pair.
    always_ff @(posedge clk) begin
        if (!rst && ld_we_s) begin
            mem_re_q[bitrev(idx_q)] <= in_re;
            mem_im_q[bitrev(idx_q)] <= in_im;
        end else if (!rst && bf_we_s) begin
            mem_re_q[j_s]  <= u_re_s;
            mem_im_q[j_s]  <= u_im_s;
            mem_re_q[jh_s] <= l_re_s;
            mem_im_q[jh_s] <= l_im_s;
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_UNLOAD);
    assign busy      = (state_q == ST_COMPUTE);
    assign done      = done_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign tw_idx    = (state_q == ST_COMPUTE) ? tw_idx_s : '0;

endmodule
